hwpf_stride_arb: RTL and testbench

- Merges the request ports of NUM_HW_PREFETCH stride prefetcher engines into the single HPDcache prefetch request port.
- Arbitrates round-robin and registers the winning request in a one-entry output buffer.
- Stamps the engine index into the request tid.
- Routes each HPDcache response back to the originating engine using that tid.
- Sits directly downstream of the stride prefetcher engines and upstream of the HPDcache requester port.

---
 rtl/hpdcache_pkg.sv | 24 ++
 rtl/hwpf_stride_pkg.sv | 6 +
 rtl/hwpf_stride_rrarb.sv | 42 ++++
 rtl/hwpf_stride_arb.sv | 79 +++++++
 tb/tb_hwpf_stride_arb.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/hpdcache_pkg.sv
// rtl/hpdcache_pkg.sv - HPDcache request/response types seen by the prefetch arbiter
package hpdcache_pkg;
    localparam int unsigned HPDCACHE_REQ_TRANS_ID_WIDTH = 4;

    typedef logic [HPDCACHE_REQ_TRANS_ID_WIDTH-1:0] hpdcache_req_tid_t;

    typedef struct packed {
        logic [31:0]       addr;
        logic [31:0]       wdata;
        logic [3:0]        be;
        logic [2:0]        op;
        logic [2:0]        size;
        logic              need_rsp;
        logic [2:0]        sid;
        hpdcache_req_tid_t tid;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0]       rdata;
        logic [2:0]        sid;
        hpdcache_req_tid_t tid;
        logic              error;
    } hpdcache_rsp_t;
endpackage

// File: rtl/hwpf_stride_pkg.sv
// rtl/hwpf_stride_pkg.sv - shared constants and engine index type for the stride prefetcher
package hwpf_stride_pkg;
    localparam int unsigned HWPF_STRIDE_MAX_ENGINES = 2 ** hpdcache_pkg::HPDCACHE_REQ_TRANS_ID_WIDTH;

    typedef logic [hpdcache_pkg::HPDCACHE_REQ_TRANS_ID_WIDTH-1:0] hwpf_stride_engine_id_t;
endpackage

// File: rtl/hwpf_stride_rrarb.sv
// rtl/hwpf_stride_rrarb.sv - round-robin arbiter, pointer advances past each winner
module hwpf_stride_rrarb #(
    parameter int unsigned N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] win;
    logic [PW:0]   idx;
    logic          found;

    // Scan from the pointer upward, wrapping, and take the first requester.
    always_comb begin
        gnt   = '0;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
        if (en && found) gnt[win] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (en && found) begin
            ptr_q <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end
endmodule

// File: rtl/hwpf_stride_arb.sv
// rtl/hwpf_stride_arb.sv - merges stride engine requests onto one HPDcache port and demuxes responses
module hwpf_stride_arb
    import hpdcache_pkg::*;
    import hwpf_stride_pkg::*;
#(
    parameter int unsigned NUM_HW_PREFETCH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_HW_PREFETCH-1:0] hwpf_req_valid_i,
    output logic [NUM_HW_PREFETCH-1:0] hwpf_req_ready_o,
    input  hpdcache_req_t              hwpf_req_i [NUM_HW_PREFETCH],
    output logic [NUM_HW_PREFETCH-1:0] hwpf_rsp_valid_o,
    output hpdcache_rsp_t              hwpf_rsp_o,
    output logic                       hpdcache_req_valid_o,
    input  logic                       hpdcache_req_ready_i,
    output hpdcache_req_t              hpdcache_req_o,
    input  logic                       hpdcache_rsp_valid_i,
    input  hpdcache_rsp_t              hpdcache_rsp_i
);
    if (NUM_HW_PREFETCH < 1 || NUM_HW_PREFETCH > HWPF_STRIDE_MAX_ENGINES) begin : g_bad_cfg
        $error("hwpf_stride_arb: NUM_HW_PREFETCH must fit in the request tid");
    end

    logic                       buf_valid_q;
    hpdcache_req_t              buf_q;
    hpdcache_req_t              req_sel;
    logic [NUM_HW_PREFETCH-1:0] gnt;
    logic                       free;

    // A grant may only be issued when the buffer empties this cycle or is already empty.
    assign free = !buf_valid_q || hpdcache_req_ready_i;

    hwpf_stride_rrarb #(.N(NUM_HW_PREFETCH)) u_rrarb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (hwpf_req_valid_i),
        .en     (free),
        .gnt    (gnt)
    );

    assign hwpf_req_ready_o = gnt;

    // The engine index replaces the tid so the response can find its way back.
    always_comb begin
        req_sel = '0;
        for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
            if (gnt[i]) begin
                req_sel     = hwpf_req_i[i];
                req_sel.tid = hwpf_stride_engine_id_t'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else if (|gnt) begin
            buf_valid_q <= 1'b1;
            buf_q       <= req_sel;
        end else if (hpdcache_req_ready_i) begin
            buf_valid_q <= 1'b0;
        end
    end

    assign hpdcache_req_valid_o = buf_valid_q;
    assign hpdcache_req_o       = buf_q;

    // Out-of-range tids match no engine and are dropped.
    assign hwpf_rsp_o = hpdcache_rsp_i;
    always_comb begin
        hwpf_rsp_valid_o = '0;
        for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
            hwpf_rsp_valid_o[i] = hpdcache_rsp_valid_i &&
                                  (hpdcache_rsp_i.tid == hwpf_stride_engine_id_t'(i));
        end
    end
endmodule

// File: tb/tb_hwpf_stride_arb.sv
// tb/tb_hwpf_stride_arb.sv - self-checking bench for hwpf_stride_arb against a queue-level model
module tb_hwpf_stride_arb;
    import hpdcache_pkg::*;

    localparam int N = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [N-1:0]  hwpf_req_valid_i = '0;
    logic [N-1:0]  hwpf_req_ready_o;
    hpdcache_req_t hwpf_req_i [N];
    logic [N-1:0]  hwpf_rsp_valid_o;
    hpdcache_rsp_t hwpf_rsp_o;
    logic          hpdcache_req_valid_o;
    logic          hpdcache_req_ready_i = 1'b0;
    hpdcache_req_t hpdcache_req_o;
    logic          hpdcache_rsp_valid_i = 1'b0;
    hpdcache_rsp_t hpdcache_rsp_i = '0;

    int total = 0;
    int bad   = 0;

    int            m_ptr;
    bit            m_valid;
    hpdcache_req_t m_buf;

    always #5 clk_i = ~clk_i;

    hwpf_stride_arb #(.NUM_HW_PREFETCH(N)) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .hwpf_req_valid_i     (hwpf_req_valid_i),
        .hwpf_req_ready_o     (hwpf_req_ready_o),
        .hwpf_req_i           (hwpf_req_i),
        .hwpf_rsp_valid_o     (hwpf_rsp_valid_o),
        .hwpf_rsp_o           (hwpf_rsp_o),
        .hpdcache_req_valid_o (hpdcache_req_valid_o),
        .hpdcache_req_ready_i (hpdcache_req_ready_i),
        .hpdcache_req_o       (hpdcache_req_o),
        .hpdcache_rsp_valid_i (hpdcache_rsp_valid_i),
        .hpdcache_rsp_i       (hpdcache_rsp_i)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic hpdcache_req_t rnd_req();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[$bits(hpdcache_req_t)-1:0];
    endfunction

    function automatic hpdcache_rsp_t rnd_rsp(input int tid);
        hpdcache_rsp_t r;
        logic [63:0] t;
        t = {$urandom, $urandom};
        r = t[$bits(hpdcache_rsp_t)-1:0];
        r.tid = hpdcache_req_tid_t'(tid);
        return r;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_buf   = '0;
    endtask

    // Inputs are already driven; check mid-cycle, then advance one clock and the model.
    task automatic step(input string tag);
        int g;
        bit fr;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_rsp;
        #3;
        fr = !m_valid || hpdcache_req_ready_i;
        g  = fr ? pick(m_ptr, hwpf_req_valid_i) : -1;
        exp_gnt = '0;
        if (g >= 0) exp_gnt[g] = 1'b1;
        exp_rsp = '0;
        if (hpdcache_rsp_valid_i && int'(hpdcache_rsp_i.tid) < N) exp_rsp[hpdcache_rsp_i.tid] = 1'b1;
        chk({tag, ".gnt"}, 128'(hwpf_req_ready_o), 128'(exp_gnt));
        chk({tag, ".vld"}, 128'(hpdcache_req_valid_o), 128'(m_valid));
        if (m_valid) chk({tag, ".req"}, 128'(hpdcache_req_o), 128'(m_buf));
        chk({tag, ".rspv"}, 128'(hwpf_rsp_valid_o), 128'(exp_rsp));
        chk({tag, ".rsp"}, 128'(hwpf_rsp_o), 128'(hpdcache_rsp_i));
        @(posedge clk_i);
        #1;
        if (g >= 0) begin
            m_buf     = hwpf_req_i[g];
            m_buf.tid = hpdcache_req_tid_t'(g);
            m_valid   = 1;
            m_ptr     = (g + 1) % N;
        end else if (hpdcache_req_ready_i) begin
            m_valid = 0;
        end
    endtask

    initial begin
        hpdcache_req_t r2;
        for (int i = 0; i < N; i++) hwpf_req_i[i] = rnd_req();
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset.vld", 128'(hpdcache_req_valid_o), 128'(0));
        chk("reset.req", 128'(hpdcache_req_o), 128'(0));
        rst_ni = 1'b1;

        // all engines streaming into an always-ready cache
        hwpf_req_valid_i = 4'b1111;
        hpdcache_req_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) hwpf_req_i[i] = rnd_req();
            step("stream");
        end

        // lone engine 2 with a foreign tid
        hwpf_req_valid_i = 4'b0100;
        r2 = rnd_req();
        r2.tid = 4'd7;
        hwpf_req_i[2] = r2;
        step("eng2a");
        step("eng2b");
        r2.tid = 4'd2;
        chk("eng2.tid", 128'(hpdcache_req_o), 128'(r2));
        step("eng2c");

        // backpressure with pointer at 0 and engines 1 and 3 waiting
        hpdcache_req_ready_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        hwpf_req_valid_i = 4'b1000;
        step("fill");
        hwpf_req_valid_i = 4'b1010;
        for (int c = 0; c < 5; c++) step("stall");
        hpdcache_req_ready_i = 1'b1;
        #3;
        chk("unstall.gnt1", 128'(hwpf_req_ready_o), 128'(4'b0010));
        #(-0);
        step("unstall1");
        hwpf_req_valid_i = 4'b1000;
        step("unstall3");
        hwpf_req_valid_i = 4'b0000;
        step("drain");

        // response demux, including an out-of-range tid
        hpdcache_rsp_valid_i = 1'b1;
        hpdcache_rsp_i = rnd_rsp(1);
        step("rsp1");
        hpdcache_rsp_i = rnd_rsp(3);
        step("rsp3");
        hpdcache_rsp_i = rnd_rsp(5);
        step("rsp5");

        // response to engine 0 in the same cycle engine 0 is granted
        hwpf_req_valid_i = 4'b0001;
        hpdcache_rsp_i = rnd_rsp(0);
        step("rspgnt");
        hwpf_req_valid_i = 4'b1111;
        hpdcache_rsp_valid_i = 1'b0;
        hpdcache_req_ready_i = 1'b0;
        step("hold");

        // asynchronous reset with the buffer full
        rst_ni = 1'b0;
        #1;
        chk("midrst.vld", 128'(hpdcache_req_valid_o), 128'(0));
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        hpdcache_req_ready_i = 1'b1;
        step("postrst");
        chk("postrst.tid", 128'(hpdcache_req_o.tid), 128'(0));

        // random traffic
        for (int c = 0; c < 400; c++) begin
            hwpf_req_valid_i = N'($urandom);
            hpdcache_req_ready_i = ($urandom_range(0, 3) != 0);
            hpdcache_rsp_valid_i = $urandom_range(0, 1) != 0;
            hpdcache_rsp_i = rnd_rsp($urandom_range(0, 15));
            for (int i = 0; i < N; i++) hwpf_req_i[i] = rnd_req();
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
